// File: rtl/crypto_pkg.sv
// ============================================================================
// Module   : crypto_pkg
// Purpose  : Shared types and defaults for the crypto frame parser datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package crypto_pkg;

  localparam int DEFAULT_DATA_WIDTH = 128;
  localparam int DEFAULT_CTR_WIDTH  = 32;
  localparam int BEAT_CNT_W         = 16;

  typedef enum logic [1:0] {
    ST_KEY     = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/axis_reg_slice.sv
// ============================================================================
// Module   : axis_reg_slice
// Purpose  : 1-entry valid/ready register stage carrying DATA + LAST.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_reg_slice #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [WIDTH-1:0] i_s_data,
  input  logic             i_s_last,
  output logic             o_m_valid,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_last,
  input  logic             i_m_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;

  // Accept whenever the stage is empty or is being emptied this cycle.
  assign o_s_ready = !r_valid || i_m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (o_s_ready) begin
      r_valid <= i_s_valid;
      if (i_s_valid) begin
        r_data <= i_s_data;
        r_last <= i_s_last;
      end
    end
  end

  assign o_m_valid = r_valid;
  assign o_m_data  = r_data;
  assign o_m_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/crypto_frame_parser.sv
// ============================================================================
// Module   : crypto_frame_parser
// Purpose  : Splits key/header/payload frames; optional CRYPTO_PARSER_LEN_OUT_EN
//            adds frame_beats (payload length of the last completed frame).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crypto_frame_parser
  import crypto_pkg::*;
#(
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int KEY_BEATS         = 1,
  parameter int CTR_WIDTH         = DEFAULT_CTR_WIDTH,
  parameter int MAX_PAYLOAD_BEATS = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]           S_AXIS_TDATA,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic                            M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  output logic [KEY_BEATS*DATA_WIDTH-1:0] key_o,
  output logic                            key_valid,
  output logic [DATA_WIDTH-CTR_WIDTH-1:0] nonce_o,
  output logic [CTR_WIDTH-1:0]            ctr_o,
  output logic                            hdr_valid,
  output logic                            frame_err
`ifdef CRYPTO_PARSER_LEN_OUT_EN
  ,
  output logic [15:0]                     frame_beats
`endif
);

  localparam int KEY_W  = KEY_BEATS * DATA_WIDTH;
  localparam int KCNT_W = (KEY_BEATS > 1) ? $clog2(KEY_BEATS) : 1;
  localparam logic [KCNT_W-1:0]     C_LAST_KEY  = KCNT_W'(KEY_BEATS - 1);
  localparam logic [BEAT_CNT_W-1:0] C_MAX_BEATS = BEAT_CNT_W'(MAX_PAYLOAD_BEATS);

  state_t                        r_state, w_next;
  logic                          r_active;
  logic [KCNT_W-1:0]             r_key_cnt;
  logic [BEAT_CNT_W-1:0]         r_beat_cnt;
  logic [KEY_W-1:0]              r_key;
  logic [DATA_WIDTH-CTR_WIDTH-1:0] r_nonce;
  logic [CTR_WIDTH-1:0]          r_ctr;
  logic                          r_key_valid, r_hdr_valid, r_frame_err;

  logic                          w_tready, w_xfer, w_slice_ready, w_slice_valid;
  logic                          w_key_done, w_key_err, w_hdr_ok, w_hdr_err;
  logic                          w_pay_end, w_trunc;
  logic [BEAT_CNT_W-1:0]         w_beat_inc;
  logic [KEY_W-1:0]              w_key_shift;

  // r_active holds TREADY low through reset and its release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_active <= 1'b0;
    else        r_active <= 1'b1;
  end

  assign w_tready      = r_active && ((r_state == ST_PAYLOAD) ? w_slice_ready : 1'b1);
  assign w_xfer        = S_AXIS_TVALID && w_tready;
  assign w_slice_valid = S_AXIS_TVALID && r_active && (r_state == ST_PAYLOAD);
  assign w_beat_inc    = r_beat_cnt + BEAT_CNT_W'(1);
  assign w_key_shift   = KEY_W'({r_key, S_AXIS_TDATA});
  assign S_AXIS_TREADY = w_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_KEY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_key_done = 1'b0;
    w_key_err  = 1'b0;
    w_hdr_ok   = 1'b0;
    w_hdr_err  = 1'b0;
    w_pay_end  = 1'b0;
    w_trunc    = 1'b0;
    case (r_state)
      ST_KEY: begin
        if (w_xfer) begin
          if (S_AXIS_TLAST) begin
            w_key_err = 1'b1;
          end else if (r_key_cnt == C_LAST_KEY) begin
            w_key_done = 1'b1;
            w_next     = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (w_xfer) begin
          if (S_AXIS_TLAST) begin
            w_hdr_err = 1'b1;
            w_next    = ST_KEY;
          end else begin
            w_hdr_ok = 1'b1;
            w_next   = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_xfer) begin
          if (S_AXIS_TLAST) begin
            w_pay_end = 1'b1;
            w_next    = ST_KEY;
          end else if (w_beat_inc == C_MAX_BEATS) begin
            w_trunc = 1'b1;
            w_next  = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (w_xfer && S_AXIS_TLAST) w_next = ST_KEY;
      end
      default: w_next = ST_KEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key       <= '0;
      r_key_cnt   <= '0;
      r_nonce     <= '0;
      r_ctr       <= '0;
      r_beat_cnt  <= '0;
      r_key_valid <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= w_key_done;
      r_hdr_valid <= w_hdr_ok;
      r_frame_err <= w_key_err || w_hdr_err || w_trunc;
      if (w_xfer && (r_state == ST_KEY)) r_key <= w_key_shift;
      if (w_key_err || w_key_done)
        r_key_cnt <= '0;
      else if (w_xfer && (r_state == ST_KEY))
        r_key_cnt <= r_key_cnt + KCNT_W'(1);
      if (w_hdr_ok) begin
        r_nonce <= S_AXIS_TDATA[DATA_WIDTH-1:CTR_WIDTH];
        r_ctr   <= S_AXIS_TDATA[CTR_WIDTH-1:0];
      end
      if (w_pay_end || w_trunc)
        r_beat_cnt <= '0;
      else if (w_xfer && (r_state == ST_PAYLOAD))
        r_beat_cnt <= w_beat_inc;
    end
  end

`ifdef CRYPTO_PARSER_LEN_OUT_EN
  logic [15:0] r_frame_beats;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_frame_beats <= '0;
    else if (w_pay_end || w_trunc) r_frame_beats <= 16'(w_beat_inc);
  end
  assign frame_beats = r_frame_beats;
`endif

  // Truncated beat leaves with LAST forced so the cipher core closes the frame.
  axis_reg_slice #(.WIDTH(DATA_WIDTH)) u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_s_valid (w_slice_valid),
    .o_s_ready (w_slice_ready),
    .i_s_data  (S_AXIS_TDATA),
    .i_s_last  (S_AXIS_TLAST || w_trunc),
    .o_m_valid (M_AXIS_TVALID),
    .o_m_data  (M_AXIS_TDATA),
    .o_m_last  (M_AXIS_TLAST),
    .i_m_ready (M_AXIS_TREADY)
  );

  assign key_o     = r_key;
  assign nonce_o   = r_nonce;
  assign ctr_o     = r_ctr;
  assign key_valid = r_key_valid;
  assign hdr_valid = r_hdr_valid;
  assign frame_err = r_frame_err;

endmodule

`default_nettype wire
